key_search_ctrl: RTL and testbench
==================================

# key_search_ctrl

Top-level scheduler for the RC4 brute-force key search. It sequences the three RC4 sub-engines per candidate key: S-box init, key-scheduling shuffle, then decrypt/check. It also arbitrates the single S-memory write/read port among them. On each failed attempt it advances the secret key and stops on success, keyspace exhaustion, sub-engine timeout or abort.

## Interface
Parameters:
- KEY_MIN, 24'h000000, first candidate key
- KEY_MAX, 24'h3FFFFF, last candidate key (inclusive)
- TIMEOUT_CYC, 65535, max cycles any single phase may run before error

Ports (reset is asynchronous, active-high; clock is clk):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin search from KEY_MIN; honoured only in IDLE, FOUND, EXHAUSTED, ERROR
- abort  in  1  return to IDLE next cycle from any state
- key  out  24  current/found candidate key; also feeds shuffle engine
- busy  out  1  high in CLEAR..NEXT_KEY
- found, exhausted, error  out  1 each  terminal status, held until next start/abort
- sub_clear  out  1  one-cycle synchronous clear to all three sub-engines
- init_start, ksa_start, dec_start  out  1 each  one-cycle start pulses
- init_done, ksa_done, dec_done  in  1 each  level, held high by engine until sub_clear
- dec_valid  in  1  decrypt result plausible; meaningful on cycle dec_done first seen
- init_addr/ksa_addr/dec_addr  in  8 each; init_data/ksa_data/dec_data  in  8 each; init_wen/ksa_wen/dec_wen  in  1 each  requester S-memory ports
- s_addr  out  8; s_data  out  8; s_wen  out  1  muxed S-memory port
- grant  out  2  0 none, 1 init, 2 ksa, 3 dec

## Operation
- States: IDLE, CLEAR, INIT_RUN, KSA_RUN, DEC_RUN, CHECK, NEXT_KEY, FOUND, EXHAUSTED, ERROR.
- IDLE/terminal states: on start, key<=KEY_MIN, clear status flags, go to CLEAR.
- CLEAR: sub_clear=1 for exactly one cycle, then INIT_RUN.
- INIT_RUN: grant=1; init_start pulses on entry cycle only; on init_done go to KSA_RUN.
- KSA_RUN: grant=2; ksa_start pulses on entry; on ksa_done go to DEC_RUN.
- DEC_RUN: grant=3; dec_start pulses on entry. On dec_done, latch dec_valid into ok_r and go to CHECK.
- CHECK: if ok_r, go to FOUND. Otherwise, if key==KEY_MAX, go to EXHAUSTED. Otherwise, go to NEXT_KEY.
- NEXT_KEY: key<=key+1, then CLEAR. Key never wraps: KEY_MAX is checked before increment.
- FOUND: found=1, key frozen at successful value. EXHAUSTED: exhausted=1, key=KEY_MAX. ERROR: error=1, key frozen at failing candidate.
- Timeout: a 16-bit phase counter is zeroed on every RUN-state entry and increments each cycle in a RUN state. If it reaches TIMEOUT_CYC before the matching done, go to ERROR.
- Done inputs of non-granted engines are ignored.
- abort has priority over all transitions. On abort: next state IDLE, sub_clear=1 that cycle, status flags cleared, key unchanged.
- start while busy is ignored.
- Memory mux: combinational on registered grant. grant=0 drives s_addr=0, s_data=0, s_wen=0. Non-granted requester writes are dropped. S-memory q is broadcast to all engines outside this block.

## Timing
- Reset: state IDLE, key=KEY_MIN, all status outputs, busy, start pulses, sub_clear and grant 0.
- start high in cycle n: CLEAR in n+1 (sub_clear=1), INIT_RUN in n+2 (init_start=1, grant=1).
- done first high in cycle m: next RUN state entered at m+1 with its start pulse.
- dec_done in cycle p: CHECK at p+1. Terminal state or NEXT_KEY at p+2; CLEAR at p+3 when retrying.
- Per-attempt overhead beyond engine latency: 5 cycles (CLEAR, 2 handoffs, CHECK, NEXT_KEY).
- busy, found, exhausted and error are registered, decoded from state.

## Test plan
- Stub engines finish in 10 cycles, dec_valid=1 on first attempt; start pulse → found=1, key=0x000000, busy=0, exactly one each of init_start, ksa_start and dec_start.
- dec_valid=0 until key 0x000005 → found=1, key=0x000005, six sub_clear pulses, grant sequence 1,2,3 repeated six times.
- KEY_MIN=0x3FFFFD, KEY_MAX=0x3FFFFF, dec_valid always 0 → exhausted=1, key=0x3FFFFF, no wrap to 0.
- TIMEOUT_CYC=20, ksa_done never asserts → error=1 exactly 20 cycles after ksa_start; key unchanged.
- Mux check: assert init_wen/ksa_wen/dec_wen simultaneously with distinct addresses (0x11, 0x22, 0x33) → s_addr and s_wen follow only the granted requester; grant=0 gives s_wen=0.
- abort mid DEC_RUN → IDLE next cycle, sub_clear=1, flags 0. Async reset mid KSA_RUN → immediate IDLE, key=KEY_MIN.

Source files
------------

// File: rtl/key_search_if.sv
// Bundles the RC4 key-search controller's handshake, status and S-memory
// port signals. master = controller side, slave = engines/host side.
interface key_search_if;
    logic        start;
    logic        abort;
    logic [23:0] key;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic        error;
    logic        sub_clear;
    logic        init_start;
    logic        ksa_start;
    logic        dec_start;
    logic        init_done;
    logic        ksa_done;
    logic        dec_done;
    logic        dec_valid;
    logic [7:0]  init_addr;
    logic [7:0]  ksa_addr;
    logic [7:0]  dec_addr;
    logic [7:0]  init_data;
    logic [7:0]  ksa_data;
    logic [7:0]  dec_data;
    logic        init_wen;
    logic        ksa_wen;
    logic        dec_wen;
    logic [7:0]  s_addr;
    logic [7:0]  s_data;
    logic        s_wen;
    logic [1:0]  grant;

    modport master (
        input  start, abort,
        input  init_done, ksa_done, dec_done, dec_valid,
        input  init_addr, ksa_addr, dec_addr,
        input  init_data, ksa_data, dec_data,
        input  init_wen, ksa_wen, dec_wen,
        output key, busy, found, exhausted, error,
        output sub_clear, init_start, ksa_start, dec_start,
        output s_addr, s_data, s_wen, grant
    );

    modport slave (
        output start, abort,
        output init_done, ksa_done, dec_done, dec_valid,
        output init_addr, ksa_addr, dec_addr,
        output init_data, ksa_data, dec_data,
        output init_wen, ksa_wen, dec_wen,
        input  key, busy, found, exhausted, error,
        input  sub_clear, init_start, ksa_start, dec_start,
        input  s_addr, s_data, s_wen, grant
    );
endinterface

// File: rtl/key_search_ctrl.sv
// RC4 brute-force key-search scheduler: sequences init/KSA/decrypt engines per
// candidate key, arbitrates the shared S-memory port, and stops on success,
// exhaustion, phase timeout or abort.
module key_search_ctrl #(
    parameter logic [23:0] KEY_MIN     = 24'h000000,
    parameter logic [23:0] KEY_MAX     = 24'h3FFFFF,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic         clk,
    input  logic         reset,
    key_search_if.master bus
);

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        INIT_RUN,
        KSA_RUN,
        DEC_RUN,
        CHECK,
        NEXT_KEY,
        FOUND,
        EXHAUSTED,
        ERROR
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_next;
    logic [23:0] key_r;
    logic        ok_r;
    logic [15:0] phase_cnt;
    logic        busy_r;
    logic        found_r;
    logic        exhausted_r;
    logic        error_r;
    logic        sub_clear_r;
    logic        init_start_r;
    logic        ksa_start_r;
    logic        dec_start_r;
    logic [1:0]  grant_r;

    logic        is_run;
    logic        timed_out;
    logic        can_start;

    function automatic logic [1:0] grant_of(input state_t s);
        case (s)
            INIT_RUN: grant_of = 2'd1;
            KSA_RUN:  grant_of = 2'd2;
            DEC_RUN:  grant_of = 2'd3;
            default:  grant_of = 2'd0;
        endcase
    endfunction

    assign is_run    = (state == INIT_RUN) || (state == KSA_RUN) || (state == DEC_RUN);
    assign timed_out = is_run && (phase_cnt == TIMEOUT_LAST);
    assign can_start = (state == IDLE) || (state == FOUND) ||
                       (state == EXHAUSTED) || (state == ERROR);

    // A done on the same cycle as the timeout still counts as completion.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, FOUND, EXHAUSTED, ERROR: begin
                if (bus.start) state_next = CLEAR;
            end
            CLEAR: state_next = INIT_RUN;
            INIT_RUN: begin
                if (bus.init_done)  state_next = KSA_RUN;
                else if (timed_out) state_next = ERROR;
            end
            KSA_RUN: begin
                if (bus.ksa_done)   state_next = DEC_RUN;
                else if (timed_out) state_next = ERROR;
            end
            DEC_RUN: begin
                if (bus.dec_done)   state_next = CHECK;
                else if (timed_out) state_next = ERROR;
            end
            CHECK: begin
                if (ok_r)                state_next = FOUND;
                else if (key_r == KEY_MAX) state_next = EXHAUSTED;
                else                     state_next = NEXT_KEY;
            end
            NEXT_KEY: state_next = CLEAR;
            default:  state_next = IDLE;
        endcase
        if (bus.abort) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            key_r     <= KEY_MIN;
            ok_r      <= 1'b0;
            phase_cnt <= 16'd0;
        end else begin
            state <= state_next;

            if (can_start && state_next == CLEAR)
                key_r <= KEY_MIN;
            else if (state == NEXT_KEY && state_next == CLEAR)
                key_r <= key_r + 24'd1;

            if (state == CLEAR)
                ok_r <= 1'b0;
            else if (state == DEC_RUN && bus.dec_done)
                ok_r <= bus.dec_valid;

            if (state_next != state)
                phase_cnt <= 16'd0;
            else if (is_run)
                phase_cnt <= phase_cnt + 16'd1;
        end
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r       <= 1'b0;
            found_r      <= 1'b0;
            exhausted_r  <= 1'b0;
            error_r      <= 1'b0;
            sub_clear_r  <= 1'b0;
            init_start_r <= 1'b0;
            ksa_start_r  <= 1'b0;
            dec_start_r  <= 1'b0;
            grant_r      <= 2'd0;
        end else begin
            busy_r       <= (state_next == CLEAR)   || (state_next == INIT_RUN) ||
                            (state_next == KSA_RUN) || (state_next == DEC_RUN)  ||
                            (state_next == CHECK)   || (state_next == NEXT_KEY);
            found_r      <= (state_next == FOUND);
            exhausted_r  <= (state_next == EXHAUSTED);
            error_r      <= (state_next == ERROR);
            sub_clear_r  <= (state_next == CLEAR) || bus.abort;
            init_start_r <= (state_next == INIT_RUN) && (state != INIT_RUN);
            ksa_start_r  <= (state_next == KSA_RUN)  && (state != KSA_RUN);
            dec_start_r  <= (state_next == DEC_RUN)  && (state != DEC_RUN);
            grant_r      <= grant_of(state_next);
        end
    end

    // Shared S-memory port: only the granted requester reaches the memory.
    always_comb begin
        bus.s_addr = 8'h00;
        bus.s_data = 8'h00;
        bus.s_wen  = 1'b0;
        case (grant_r)
            2'd1: begin
                bus.s_addr = bus.init_addr;
                bus.s_data = bus.init_data;
                bus.s_wen  = bus.init_wen;
            end
            2'd2: begin
                bus.s_addr = bus.ksa_addr;
                bus.s_data = bus.ksa_data;
                bus.s_wen  = bus.ksa_wen;
            end
            2'd3: begin
                bus.s_addr = bus.dec_addr;
                bus.s_data = bus.dec_data;
                bus.s_wen  = bus.dec_wen;
            end
            default: ;
        endcase
    end

    assign bus.key        = key_r;
    assign bus.busy       = busy_r;
    assign bus.found      = found_r;
    assign bus.exhausted  = exhausted_r;
    assign bus.error      = error_r;
    assign bus.sub_clear  = sub_clear_r;
    assign bus.init_start = init_start_r;
    assign bus.ksa_start  = ksa_start_r;
    assign bus.dec_start  = dec_start_r;
    assign bus.grant      = grant_r;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: two instances with stub engines, one for
// search/timeout/abort scenarios and one configured near the top of the keyspace.
module tb_key_search_ctrl;

    localparam int LAT = 10;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    key_search_if ia ();
    key_search_if ib ();

    key_search_ctrl #(
        .KEY_MIN(24'h000000), .KEY_MAX(24'h3FFFFF), .TIMEOUT_CYC(20)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ia)
    );

    key_search_ctrl #(
        .KEY_MIN(24'h3FFFFD), .KEY_MAX(24'h3FFFFF), .TIMEOUT_CYC(65535)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ib)
    );

    // Stub engines for instance A: done rises LAT cycles after a start pulse.
    logic        a_init_en, a_ksa_en, a_dec_en;
    logic [23:0] a_target;
    int          a_cnt;
    int          a_act;

    assign ia.dec_valid = (ia.key == a_target);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ia.init_done <= 1'b0; ia.ksa_done <= 1'b0; ia.dec_done <= 1'b0;
            a_act <= 0; a_cnt <= 0;
        end else if (ia.sub_clear) begin
            ia.init_done <= 1'b0; ia.ksa_done <= 1'b0; ia.dec_done <= 1'b0;
            a_act <= 0;
        end else if (ia.init_start) begin
            a_act <= 1; a_cnt <= 1;
        end else if (ia.ksa_start) begin
            a_act <= 2; a_cnt <= 1;
        end else if (ia.dec_start) begin
            a_act <= 3; a_cnt <= 1;
        end else if (a_act != 0) begin
            if (a_cnt == LAT) begin
                if (a_act == 1) ia.init_done <= a_init_en;
                if (a_act == 2) ia.ksa_done  <= a_ksa_en;
                if (a_act == 3) ia.dec_done  <= a_dec_en;
                a_act <= 0;
            end else begin
                a_cnt <= a_cnt + 1;
            end
        end
    end

    // Stub engines for instance B: always finish, never a valid decrypt.
    int b_cnt;
    int b_act;

    assign ib.dec_valid = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ib.init_done <= 1'b0; ib.ksa_done <= 1'b0; ib.dec_done <= 1'b0;
            b_act <= 0; b_cnt <= 0;
        end else if (ib.sub_clear) begin
            ib.init_done <= 1'b0; ib.ksa_done <= 1'b0; ib.dec_done <= 1'b0;
            b_act <= 0;
        end else if (ib.init_start) begin
            b_act <= 1; b_cnt <= 1;
        end else if (ib.ksa_start) begin
            b_act <= 2; b_cnt <= 1;
        end else if (ib.dec_start) begin
            b_act <= 3; b_cnt <= 1;
        end else if (b_act != 0) begin
            if (b_cnt == LAT) begin
                if (b_act == 1) ib.init_done <= 1'b1;
                if (b_act == 2) ib.ksa_done  <= 1'b1;
                if (b_act == 3) ib.dec_done  <= 1'b1;
                b_act <= 0;
            end else begin
                b_cnt <= b_cnt + 1;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ia.busy); end
        total++; if ({ia.found, ia.exhausted, ia.error} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {ia.found, ia.exhausted, ia.error}); end
        total++; if ({ia.sub_clear, ia.init_start, ia.ksa_start, ia.dec_start} !== 4'b0000) begin bad++; $display("FAIL reset_pulses: got %b want 0000", {ia.sub_clear, ia.init_start, ia.ksa_start, ia.dec_start}); end
        total++; if (ia.grant !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", ia.grant); end
        total++; if (ia.key !== 24'h000000) begin bad++; $display("FAIL reset_key_a: got %h want 000000", ia.key); end
        total++; if (ib.key !== 24'h3FFFFD) begin bad++; $display("FAIL reset_key_b: got %h want 3ffffd", ib.key); end
        total++; if ({ia.s_wen, ia.s_addr, ia.s_data} !== 17'd0) begin bad++; $display("FAIL reset_mux_idle: got wen=%b addr=%h data=%h want 0/00/00", ia.s_wen, ia.s_addr, ia.s_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_attempt();
        int ni, nk, nd;
        a_target = 24'h000000;
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        total++; if (ia.sub_clear !== 1'b1) begin bad++; $display("FAIL first_clear_cycle: sub_clear got %b want 1", ia.sub_clear); end
        total++; if (ia.busy !== 1'b1) begin bad++; $display("FAIL first_busy: got %b want 1", ia.busy); end
        @(negedge clk);
        total++; if (ia.init_start !== 1'b1 || ia.grant !== 2'd1) begin bad++; $display("FAIL first_init_entry: init_start=%b grant=%0d want 1/1", ia.init_start, ia.grant); end
        total++; if (ia.sub_clear !== 1'b0) begin bad++; $display("FAIL first_clear_width: sub_clear got %b want 0", ia.sub_clear); end
        ni = 1; nk = 0; nd = 0;
        for (int i = 0; i < 500 && !ia.found; i++) begin
            @(negedge clk);
            if (ia.init_start) ni++;
            if (ia.ksa_start)  nk++;
            if (ia.dec_start)  nd++;
        end
        total++; if (ia.found !== 1'b1) begin bad++; $display("FAIL first_found: got %b want 1", ia.found); end
        total++; if (ia.key !== 24'h000000) begin bad++; $display("FAIL first_key: got %h want 000000", ia.key); end
        total++; if (ia.busy !== 1'b0) begin bad++; $display("FAIL first_busy_end: got %b want 0", ia.busy); end
        total++; if (ni != 1 || nk != 1 || nd != 1) begin bad++; $display("FAIL first_start_pulses: got %0d/%0d/%0d want 1/1/1", ni, nk, nd); end
    endtask

    task automatic test_retry_and_mux();
        int       nsc;
        int       mux_bad;
        logic [1:0] prev;
        logic [1:0] gseq[$];
        logic [7:0] want_addr, want_data;
        logic       want_wen;
        int       seq_bad;
        a_target = 24'h000005;
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        nsc = 0; mux_bad = 0; prev = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if (ia.sub_clear) nsc++;
            if (ia.grant != prev && ia.grant != 2'd0) gseq.push_back(ia.grant);
            prev = ia.grant;
            case (ia.grant)
                2'd1:    begin want_addr = 8'h11; want_data = 8'hA1; want_wen = 1'b1; end
                2'd2:    begin want_addr = 8'h22; want_data = 8'hB2; want_wen = 1'b1; end
                2'd3:    begin want_addr = 8'h33; want_data = 8'hC3; want_wen = 1'b1; end
                default: begin want_addr = 8'h00; want_data = 8'h00; want_wen = 1'b0; end
            endcase
            if (ia.s_addr !== want_addr || ia.s_data !== want_data || ia.s_wen !== want_wen) begin
                if (mux_bad == 0)
                    $display("FAIL mux_route: grant=%0d got addr=%h data=%h wen=%b want %h/%h/%b",
                             ia.grant, ia.s_addr, ia.s_data, ia.s_wen, want_addr, want_data, want_wen);
                mux_bad++;
            end
            if (ia.found) break;
            @(negedge clk);
        end
        seq_bad = 0;
        foreach (gseq[i]) if (gseq[i] != 2'((i % 3) + 1)) seq_bad++;
        total++; if (mux_bad != 0) begin bad++; $display("FAIL mux_summary: got %0d bad cycles want 0", mux_bad); end
        total++; if (ia.found !== 1'b1) begin bad++; $display("FAIL retry_found: got %b want 1", ia.found); end
        total++; if (ia.key !== 24'h000005) begin bad++; $display("FAIL retry_key: got %h want 000005", ia.key); end
        total++; if (nsc != 6) begin bad++; $display("FAIL retry_sub_clear: got %0d want 6", nsc); end
        total++; if (gseq.size() != 18 || seq_bad != 0) begin bad++; $display("FAIL retry_grant_seq: got len=%0d off=%0d want 18/0", gseq.size(), seq_bad); end
    endtask

    task automatic test_timeout();
        int n;
        a_target = 24'hFFFFFF;
        a_ksa_en = 1'b0;
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        for (int i = 0; i < 200 && !ia.ksa_start; i++) @(negedge clk);
        total++; if (ia.ksa_start !== 1'b1) begin bad++; $display("FAIL timeout_ksa_start: got %b want 1", ia.ksa_start); end
        n = 0;
        while (!ia.error && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (ia.error !== 1'b1) begin bad++; $display("FAIL timeout_error: got %b want 1", ia.error); end
        total++; if (n != 20) begin bad++; $display("FAIL timeout_cycles: got %0d want 20", n); end
        total++; if (ia.key !== 24'h000000 || ia.busy !== 1'b0) begin bad++; $display("FAIL timeout_key_busy: got key=%h busy=%b want 000000/0", ia.key, ia.busy); end
        a_ksa_en = 1'b1;
    endtask

    task automatic test_abort();
        logic [23:0] key_before;
        a_target = 24'hFFFFFF;
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        for (int i = 0; i < 500 && !(ia.key == 24'h000001 && ia.grant == 2'd3); i++) @(negedge clk);
        total++; if (ia.grant !== 2'd3 || ia.key !== 24'h000001) begin bad++; $display("FAIL abort_reach_dec: got grant=%0d key=%h want 3/000001", ia.grant, ia.key); end
        key_before = ia.key;
        ia.abort = 1'b1;
        @(negedge clk);
        ia.abort = 1'b0;
        total++; if (ia.busy !== 1'b0 || ia.grant !== 2'd0) begin bad++; $display("FAIL abort_idle: got busy=%b grant=%0d want 0/0", ia.busy, ia.grant); end
        total++; if (ia.sub_clear !== 1'b1) begin bad++; $display("FAIL abort_sub_clear: got %b want 1", ia.sub_clear); end
        total++; if ({ia.found, ia.exhausted, ia.error} !== 3'b000) begin bad++; $display("FAIL abort_flags: got %b want 000", {ia.found, ia.exhausted, ia.error}); end
        total++; if (ia.key !== key_before) begin bad++; $display("FAIL abort_key: got %h want %h", ia.key, key_before); end
        @(negedge clk);
        total++; if (ia.sub_clear !== 1'b0 || ia.busy !== 1'b0) begin bad++; $display("FAIL abort_settle: got sub_clear=%b busy=%b want 0/0", ia.sub_clear, ia.busy); end
        // Abort from a terminal state drops the status flag.
        a_target = 24'h000000;
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        for (int i = 0; i < 500 && !ia.found; i++) @(negedge clk);
        ia.abort = 1'b1;
        @(negedge clk);
        ia.abort = 1'b0;
        total++; if (ia.found !== 1'b0) begin bad++; $display("FAIL abort_found_clear: got %b want 0", ia.found); end
    endtask

    task automatic test_busy_start_and_reset();
        a_target = 24'hFFFFFF;
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        for (int i = 0; i < 500 && !(ia.key == 24'h000002 && ia.grant == 2'd2); i++) @(negedge clk);
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        total++; if (ia.key !== 24'h000002 || ia.busy !== 1'b1) begin bad++; $display("FAIL busy_start_ignored: got key=%h busy=%b want 000002/1", ia.key, ia.busy); end
        total++; if (ia.grant !== 2'd2) begin bad++; $display("FAIL busy_still_ksa: got grant=%0d want 2", ia.grant); end
        reset = 1'b1;
        #1;
        total++; if (ia.busy !== 1'b0 || ia.grant !== 2'd0) begin bad++; $display("FAIL async_reset_idle: got busy=%b grant=%0d want 0/0", ia.busy, ia.grant); end
        total++; if (ia.key !== 24'h000000) begin bad++; $display("FAIL async_reset_key: got %h want 000000", ia.key); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exhaust();
        int nsc;
        int wrapped;
        ib.start = 1'b1;
        @(negedge clk);
        ib.start = 1'b0;
        nsc = 0; wrapped = 0;
        for (int i = 0; i < 2000; i++) begin
            if (ib.sub_clear) nsc++;
            if (ib.key < 24'h3FFFFD) wrapped++;
            if (ib.exhausted) break;
            @(negedge clk);
        end
        total++; if (ib.exhausted !== 1'b1 || ib.found !== 1'b0) begin bad++; $display("FAIL exhaust_flag: got exhausted=%b found=%b want 1/0", ib.exhausted, ib.found); end
        total++; if (ib.key !== 24'h3FFFFF) begin bad++; $display("FAIL exhaust_key: got %h want 3fffff", ib.key); end
        total++; if (wrapped != 0) begin bad++; $display("FAIL exhaust_wrap: got %0d low-key cycles want 0", wrapped); end
        total++; if (nsc != 3) begin bad++; $display("FAIL exhaust_attempts: got %0d want 3", nsc); end
        @(negedge clk);
        total++; if (ib.exhausted !== 1'b1 || ib.busy !== 1'b0) begin bad++; $display("FAIL exhaust_hold: got exhausted=%b busy=%b want 1/0", ib.exhausted, ib.busy); end
    endtask

    initial begin
        reset = 1'b1;
        ia.start = 1'b0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.abort = 1'b0;
        a_init_en = 1'b1; a_ksa_en = 1'b1; a_dec_en = 1'b1;
        a_target = 24'hFFFFFF;
        ia.init_addr = 8'h11; ia.init_data = 8'hA1; ia.init_wen = 1'b1;
        ia.ksa_addr  = 8'h22; ia.ksa_data  = 8'hB2; ia.ksa_wen  = 1'b1;
        ia.dec_addr  = 8'h33; ia.dec_data  = 8'hC3; ia.dec_wen  = 1'b1;
        ib.init_addr = 8'h00; ib.init_data = 8'h00; ib.init_wen = 1'b0;
        ib.ksa_addr  = 8'h00; ib.ksa_data  = 8'h00; ib.ksa_wen  = 1'b0;
        ib.dec_addr  = 8'h00; ib.dec_data  = 8'h00; ib.dec_wen  = 1'b0;
        test_reset();
        test_first_attempt();
        test_retry_and_mux();
        test_timeout();
        test_abort();
        test_busy_start_and_reset();
        test_exhaust();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
